// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared arbiter state encoding, port ids and default memory widths
package mips_mem_pkg;

    typedef enum logic {IF_PRIO, DR_FORCE} arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DR = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of consecutive denied DR cycles; hit flags the cycle whose denial reaches LIMIT
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = LIMIT[W-1:0];

    logic [W-1:0] cnt, cnt_nxt;

    // next count: clear wins, otherwise increment until saturated at LIM
    always_comb begin
        cnt_nxt = clr ? '0 : (inc && cnt != LIM) ? cnt + 1'b1 : cnt;
        hit     = inc && !clr && cnt_nxt == LIM;
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one combinational ROM between fetch (IF) and data read (DR),
// one grant per cycle, registered read data; optional range check via ROM_RANGE_CHECK_EN
module rom_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int ROM_DEPTH    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dr_req,
    input  logic [ADDR_WIDTH-1:0] dr_addr,
    output logic                  dr_gnt,
    output logic                  dr_rvalid,
    output logic [DATA_WIDTH-1:0] dr_rdata,
`ifdef ROM_RANGE_CHECK_EN
    output logic                  if_err,
    output logic                  dr_err,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data
);

    if (STARVE_LIMIT < 1 || ROM_DEPTH < 1) begin : g_bad_param
        $error("rom_port_arbiter: STARVE_LIMIT and ROM_DEPTH must be >= 1");
    end

    arb_state_t            state, state_nxt;
    logic                  win;
    logic                  hit;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DATA_WIDTH-1:0] cap;

    arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (dr_req && !dr_gnt),
        .clr  (!dr_req || dr_gnt),
        .hit  (hit)
    );

`ifdef ROM_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH = ROM_DEPTH[ADDR_WIDTH:0];
    logic oor;
    assign oor = {1'b0, rom_addr} >= DEPTH;
    assign cap = oor ? '0 : rom_data;
`else
    assign cap = rom_data;
`endif

    // grant, ROM address mux and next arbitration state
    always_comb begin
        if_gnt    = if_req && (state == IF_PRIO || !dr_req);
        dr_gnt    = dr_req && !if_gnt;
        win       = if_gnt ? PORT_IF : PORT_DR;
        rom_addr  = (if_gnt || dr_gnt) ? ((win == PORT_IF) ? if_addr : dr_addr) : last_addr;
        state_nxt = (state == IF_PRIO) ? (hit ? DR_FORCE : IF_PRIO)
                                       : ((dr_gnt || !dr_req) ? IF_PRIO : DR_FORCE);
    end

    // arbitration state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IF_PRIO;
        else
            state <= state_nxt;
    end

    // response registers: winner captures the ROM word, losers keep their data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            dr_rvalid <= 1'b0;
            if_rdata  <= '0;
            dr_rdata  <= '0;
            last_addr <= '0;
        end else begin
            if_rvalid <= if_gnt;
            dr_rvalid <= dr_gnt;
            last_addr <= rom_addr;
            if (if_gnt)
                if_rdata <= cap;
            if (dr_gnt)
                dr_rdata <= cap;
        end
    end

`ifdef ROM_RANGE_CHECK_EN
    // error flags pulse alongside the rvalid of an out-of-range read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_err <= 1'b0;
            dr_err <= 1'b0;
        end else begin
            if_err <= if_gnt && oor;
            dr_err <= dr_gnt && oor;
        end
    end
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed checks of grant order, starvation release, read data, reset and range check
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, dr_req = 1'b0;
    logic [9:0]  if_addr = '0, dr_addr = '0;
    logic        if_gnt, dr_gnt, if_rvalid, dr_rvalid;
    logic [31:0] if_rdata, dr_rdata;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
`ifdef ROM_RANGE_CHECK_EN
    logic        if_err, dr_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'hA500_0000 + {22'd0, rom_addr};

    rom_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .ROM_DEPTH(256), .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .dr_req   (dr_req),
        .dr_addr  (dr_addr),
        .dr_gnt   (dr_gnt),
        .dr_rvalid(dr_rvalid),
        .dr_rdata (dr_rdata),
`ifdef ROM_RANGE_CHECK_EN
        .if_err   (if_err),
        .dr_err   (dr_err),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_dr;
        // reset state
        #12;
        chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("rst_dr_rvalid", 64'(dr_rvalid), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_dr_rdata", 64'(dr_rdata), 64'd0);
        chk("rst_rom_addr", 64'(rom_addr), 64'd0);
        chk("rst_gnts", 64'({if_gnt, dr_gnt}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: IF only, consecutive addresses
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1;
            if_addr = 10'(i);
            #1;
            chk("t1_if_gnt", 64'(if_gnt), 64'd1);
            chk("t1_dr_gnt", 64'(dr_gnt), 64'd0);
            chk("t1_rom_addr", 64'(rom_addr), 64'(i));
            tick();
            chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
            chk("t1_if_rdata", 64'(if_rdata), 64'(32'hA500_0000 + i));
`ifdef ROM_RANGE_CHECK_EN
            chk("t1_if_err", 64'(if_err), 64'd0);
`endif
        end
        if_req = 1'b0;
        #1;
        chk("t1_idle_gnt", 64'(if_gnt), 64'd0);
        chk("t1_hold_addr", 64'(rom_addr), 64'd3);
        tick();
        chk("t1_idle_rvalid", 64'(if_rvalid), 64'd0);
        chk("t1_hold_rdata", 64'(if_rdata), 64'hA500_0003);

        // 2: DR only
        dr_req = 1'b1;
        dr_addr = 10'd7;
        #1;
        chk("t2_dr_gnt", 64'(dr_gnt), 64'd1);
        chk("t2_if_gnt", 64'(if_gnt), 64'd0);
        tick();
        dr_req = 1'b0;
        chk("t2_dr_rvalid", 64'(dr_rvalid), 64'd1);
        chk("t2_dr_rdata", 64'(dr_rdata), 64'hA500_0007);
        chk("t2_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("t2_if_rdata_held", 64'(if_rdata), 64'hA500_0003);
        tick();
        chk("t2_dr_rvalid_end", 64'(dr_rvalid), 64'd0);

        // 3: both held 10 cycles -> IF x4, DR, IF x4, DR
        if_req = 1'b1;
        if_addr = 10'd10;
        dr_req = 1'b1;
        dr_addr = 10'd20;
        for (int k = 0; k < 10; k++) begin
            exp_dr = (k % 5) == 4;
            #1;
            chk("t3_if_gnt", 64'(if_gnt), 64'(!exp_dr));
            chk("t3_dr_gnt", 64'(dr_gnt), 64'(exp_dr));
            chk("t3_not_both", 64'(if_gnt && dr_gnt), 64'd0);
            tick();
            chk("t3_if_rvalid", 64'(if_rvalid), 64'(!exp_dr));
            chk("t3_dr_rvalid", 64'(dr_rvalid), 64'(exp_dr));
            if (exp_dr)
                chk("t3_dr_rdata", 64'(dr_rdata), 64'hA500_0014);
            else
                chk("t3_if_rdata", 64'(if_rdata), 64'hA500_000A);
        end
        if_req = 1'b0;
        dr_req = 1'b0;
        tick();

        // 4: DR denied 3, drops 1, then needs 4 more denials
        if_req = 1'b1;
        dr_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_pre_denied", 64'(dr_gnt), 64'd0);
            tick();
        end
        dr_req = 1'b0;
        #1;
        chk("t4_drop_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        dr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_denied", 64'(dr_gnt), 64'd0);
            tick();
        end
        #1;
        chk("t4_forced_dr", 64'(dr_gnt), 64'd1);
        chk("t4_forced_if", 64'(if_gnt), 64'd0);
        tick();
        chk("t4_dr_rvalid", 64'(dr_rvalid), 64'd1);
        dr_req = 1'b0;

        // 5: reset while an IF read is in flight
        if_addr = 10'd5;
        #1;
        chk("t5_if_gnt", 64'(if_gnt), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("t5_rst_dr_rvalid", 64'(dr_rvalid), 64'd0);
        chk("t5_rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("t5_rst_dr_rdata", 64'(dr_rdata), 64'd0);
        tick();
        chk("t5_no_late_rvalid", 64'(if_rvalid), 64'd0);
        rst_n = 1'b1;
        dr_req = 1'b1;
        dr_addr = 10'd9;
        #1;
        chk("t5_first_if", 64'(if_gnt), 64'd1);
        chk("t5_first_dr", 64'(dr_gnt), 64'd0);
        tick();
        chk("t5_if_rdata", 64'(if_rdata), 64'hA500_0005);
        dr_req = 1'b0;

        // 6: out-of-range address
        if_addr = 10'd300;
        #1;
        chk("t6_if_gnt", 64'(if_gnt), 64'd1);
        tick();
        if_req = 1'b0;
        chk("t6_if_rvalid", 64'(if_rvalid), 64'd1);
`ifdef ROM_RANGE_CHECK_EN
        chk("t6_if_rdata", 64'(if_rdata), 64'd0);
        chk("t6_if_err", 64'(if_err), 64'd1);
        chk("t6_dr_err", 64'(dr_err), 64'd0);
        tick();
        chk("t6_if_err_end", 64'(if_err), 64'd0);
`else
        chk("t6_if_rdata", 64'(if_rdata), 64'hA500_012C);
        tick();
`endif
        chk("t6_if_rvalid_end", 64'(if_rvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
